// File: rtl/bat_loader_pkg.sv
// ============================================================================
// Module  : bat_loader_pkg
// Purpose : Shared widths, state encoding and helpers for the boot loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bat_loader_pkg;

   localparam int LOADER_WORD_W = 16;
   localparam int LOADER_BYTE_W = 8;
   localparam int STATE_W       = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_WORD_HI = 3'd3,
      S_WORD_LO = 3'd4,
      S_WRITE   = 3'd5,
      S_RELEASE = 3'd6,
      S_RUN     = 3'd7
   } loader_state_t;

   function automatic logic [LOADER_WORD_W-1:0] join_bytes(
      input logic [LOADER_BYTE_W-1:0] hi,
      input logic [LOADER_BYTE_W-1:0] lo
   );
      return {hi, lo};
   endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// Module  : program_loader_if
// Purpose : Byte stream handshake plus CPU RAM/HALT port of the boot loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
   import bat_loader_pkg::*;

   logic [LOADER_BYTE_W-1:0] rx_data;
   logic                     rx_valid;
   logic                     rx_ready;
   logic                     load_req;
   logic                     halt;
   logic [LOADER_WORD_W-1:0] address;
   logic                     addr_oe;
   logic [LOADER_WORD_W-1:0] data_out;
   logic                     data_oe;
   logic                     ram_rw;
   logic                     ram_en;
   logic                     done;

   modport master (
      input  rx_data, rx_valid, load_req,
      output rx_ready, halt, address, addr_oe, data_out, data_oe,
             ram_rw, ram_en, done
   );

   modport slave (
      output rx_data, rx_valid, load_req,
      input  rx_ready, halt, address, addr_oe, data_out, data_oe,
             ram_rw, ram_en, done
   );

endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module  : program_loader
// Purpose : Holds the CPU in HALT, loads a length-prefixed word image into RAM
//           from a byte stream, then releases the CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader
   import bat_loader_pkg::*;
#(
   parameter logic [LOADER_WORD_W-1:0] BASE_ADDR    = 16'h0000,
   parameter int unsigned              WRITE_CYCLES = 1,
   parameter bit                       AUTO_START   = 1'b1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   program_loader_if.master  bus
);

   localparam loader_state_t c_RESET_STATE = AUTO_START ? S_LEN_HI : S_IDLE;
   localparam logic [3:0]    c_WCNT_LOAD   = 4'(WRITE_CYCLES - 1);

   loader_state_t            state_r, state_n;
   logic [LOADER_BYTE_W-1:0] hi_r, hi_n;
   logic [LOADER_WORD_W-1:0] rem_r, rem_n;
   logic [3:0]               wcnt_r, wcnt_n;
   logic [LOADER_WORD_W-1:0] addr_r, addr_n;
   logic [LOADER_WORD_W-1:0] dout_r, dout_n;
   logic                     halt_r, halt_n;
   logic                     en_r, en_n;
   logic                     done_r, done_n;

   logic                     w_stream_state;
   logic                     w_rx_ready;
   logic                     w_accept;
   logic [LOADER_WORD_W-1:0] w_rx_word;

   assign w_stream_state = (state_r == S_LEN_HI)  || (state_r == S_LEN_LO) ||
                           (state_r == S_WORD_HI) || (state_r == S_WORD_LO);
   assign w_rx_ready     = w_stream_state && !rst;
   assign w_accept       = bus.rx_valid && w_rx_ready;
   assign w_rx_word      = join_bytes(hi_r, bus.rx_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= c_RESET_STATE;
         hi_r    <= '0;
         rem_r   <= '0;
         wcnt_r  <= '0;
         addr_r  <= BASE_ADDR;
         dout_r  <= '0;
         halt_r  <= 1'b1;
         en_r    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         hi_r    <= hi_n;
         rem_r   <= rem_n;
         wcnt_r  <= wcnt_n;
         addr_r  <= addr_n;
         dout_r  <= dout_n;
         halt_r  <= halt_n;
         en_r    <= en_n;
         done_r  <= done_n;
      end
   end

   // Outputs are computed for the state being entered so they register in
   // step with the state change.
   always_comb begin
      state_n = state_r;
      hi_n    = hi_r;
      rem_n   = rem_r;
      wcnt_n  = wcnt_r;
      addr_n  = addr_r;
      dout_n  = dout_r;
      halt_n  = halt_r;
      en_n    = 1'b0;
      done_n  = done_r;

      case (state_r)
         S_IDLE, S_RUN: begin
            if (bus.load_req) begin
               state_n = S_LEN_HI;
               addr_n  = BASE_ADDR;
               done_n  = 1'b0;
               halt_n  = 1'b1;
            end
         end
         S_LEN_HI: begin
            if (w_accept) begin
               hi_n    = bus.rx_data;
               state_n = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (w_accept) begin
               rem_n   = w_rx_word;
               state_n = (w_rx_word == '0) ? S_RELEASE : S_WORD_HI;
            end
         end
         S_WORD_HI: begin
            if (w_accept) begin
               hi_n    = bus.rx_data;
               state_n = S_WORD_LO;
            end
         end
         S_WORD_LO: begin
            if (w_accept) begin
               dout_n  = w_rx_word;
               wcnt_n  = c_WCNT_LOAD;
               en_n    = 1'b1;
               state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            if (wcnt_r == 4'd0) begin
               addr_n  = addr_r + 16'd1;
               rem_n   = rem_r - 16'd1;
               state_n = (rem_n == '0) ? S_RELEASE : S_WORD_HI;
            end else begin
               wcnt_n  = wcnt_r - 4'd1;
               en_n    = 1'b1;
            end
         end
         S_RELEASE: begin
            state_n = S_RUN;
            halt_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign bus.rx_ready = w_rx_ready;
   assign bus.halt     = halt_r;
   assign bus.addr_oe  = halt_r;
   assign bus.address  = addr_r;
   assign bus.data_out = dout_r;
   assign bus.data_oe  = en_r;
   assign bus.ram_rw   = en_r;
   assign bus.ram_en   = en_r;
   assign bus.done     = done_r;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module  : tb_program_loader
// Purpose : Self-checking bench for program_loader (three parameterisations).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

   logic clk;
   logic rst_a, rst_b, rst_c;
   int   compared;
   int   mismatched;

   program_loader_if a_if ();
   program_loader_if b_if ();
   program_loader_if c_if ();

   program_loader #(.BASE_ADDR(16'h0000), .WRITE_CYCLES(1), .AUTO_START(1'b1))
      dut_a (.clk(clk), .rst(rst_a), .bus(a_if.master));
   program_loader #(.BASE_ADDR(16'hFFFF), .WRITE_CYCLES(3), .AUTO_START(1'b1))
      dut_b (.clk(clk), .rst(rst_b), .bus(b_if.master));
   program_loader #(.BASE_ADDR(16'h0000), .WRITE_CYCLES(1), .AUTO_START(1'b0))
      dut_c (.clk(clk), .rst(rst_c), .bus(c_if.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        lr;
      logic        rdy;
      logic        h;
      logic        en;
      logic        dn;
      logic [15:0] a;
      logic [15:0] q;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      int          len;
   } wr_t;

   wr_t wr_b[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Records every RAM_EN pulse of dut_b and checks the write bus stays put.
   initial begin
      bit  inp;
      wr_t cur;
      inp = 1'b0;
      cur = '{16'h0, 16'h0, 0};
      forever begin
         @(negedge clk);
         if (b_if.ram_en) begin
            if (!inp) begin
               cur.addr = b_if.address;
               cur.data = b_if.data_out;
               cur.len  = 0;
               inp      = 1'b1;
            end
            cur.len++;
            chk("b_write_stable",
                {b_if.ram_rw, b_if.data_oe, b_if.rx_ready, b_if.halt, b_if.address, b_if.data_out},
                {1'b1, 1'b1, 1'b0, 1'b1, cur.addr, cur.data});
         end else if (inp) begin
            wr_b.push_back(cur);
            inp = 1'b0;
         end
      end
   end

   task automatic send_b(input logic [7:0] b, input bit stall);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         b_if.rx_data  = b;
         b_if.rx_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         acc = b_if.rx_valid && b_if.rx_ready;
         @(posedge clk); #1;
         n++;
      end
      b_if.rx_valid = 1'b0;
      chk("b_send_accepted", {63'd0, acc}, 64'd1);
   endtask

   task automatic wait_done_b();
      int n;
      n = 0;
      while (!b_if.done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_done_reached", {63'd0, b_if.done}, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[24];
      logic [15:0] ea[4];
      logic [15:0] ed[4];

      compared   = 0;
      mismatched = 0;

      tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[3]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234};
      tbl[5]  = '{1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h1234};
      tbl[6]  = '{1'b1, 8'hCD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h1234};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'hABCD};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'hABCD};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hABCD};
      tbl[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hABCD};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hABCD};
      tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD};
      tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD};
      tbl[14] = '{1'b1, 8'hBE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD};
      tbl[15] = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
      tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hBEEF};
      tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hBEEF};
      tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hBEEF};
      tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
      tbl[21] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
      tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
      tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF};

      ea[0] = 16'hFFFF; ea[1] = 16'h0000; ea[2] = 16'h0001; ea[3] = 16'h0002;
      ed[0] = 16'hA1B2; ed[1] = 16'hC3D4; ed[2] = 16'hE5F6; ed[3] = 16'h0718;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      a_if.rx_valid = 1'b0; a_if.rx_data = 8'h00; a_if.load_req = 1'b0;
      b_if.rx_valid = 1'b0; b_if.rx_data = 8'h00; b_if.load_req = 1'b0;
      c_if.rx_valid = 1'b0; c_if.rx_data = 8'h00; c_if.load_req = 1'b0;

      // Reset values (rx_ready forced low while reset is held)
      @(posedge clk); @(posedge clk); #1;
      chk("a_in_reset",
          {a_if.rx_ready, a_if.halt, a_if.addr_oe, a_if.ram_en, a_if.ram_rw, a_if.data_oe,
           a_if.done, a_if.address, a_if.data_out},
          {7'b0110000, 16'h0000, 16'h0000});
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      #1;
      chk("b_after_reset",
          {b_if.rx_ready, b_if.halt, b_if.addr_oe, b_if.ram_en, b_if.ram_rw, b_if.data_oe,
           b_if.done, b_if.address, b_if.data_out},
          {7'b1110000, 16'hFFFF, 16'h0000});
      chk("c_after_reset_idle",
          {c_if.rx_ready, c_if.halt, c_if.addr_oe, c_if.ram_en, c_if.done, c_if.address},
          {5'b01100, 16'h0000});

      // Table-driven cycle-by-cycle run of dut_a
      for (int k = 0; k < 24; k++) begin
         a_if.rx_valid = tbl[k].v;
         a_if.rx_data  = tbl[k].d;
         a_if.load_req = tbl[k].lr;
         #1;
         chk($sformatf("a_vec%0d", k),
             {a_if.rx_ready, a_if.halt, a_if.addr_oe, a_if.ram_en, a_if.ram_rw, a_if.data_oe,
              a_if.done, a_if.address, a_if.data_out},
             {tbl[k].rdy, tbl[k].h, tbl[k].h, tbl[k].en, tbl[k].en, tbl[k].en,
              tbl[k].dn, tbl[k].a, tbl[k].q});
         @(posedge clk); #1;
      end
      a_if.rx_valid = 1'b0;
      a_if.load_req = 1'b0;

      // dut_c waits in IDLE until LOAD_REQ
      c_if.rx_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("c_idle_ignores_stream", {c_if.rx_ready, c_if.halt, c_if.done}, 3'b010);
      c_if.load_req = 1'b1;
      @(posedge clk); #1;
      c_if.load_req = 1'b0;
      c_if.rx_valid = 1'b0;
      chk("c_load_req_to_len_hi", {c_if.rx_ready, c_if.halt, c_if.address}, {2'b11, 16'h0000});

      // dut_b: 4 words with random stalls, address wraps from FFFF
      send_b(8'h00, 1'b1);
      send_b(8'h04, 1'b1);
      for (int w = 0; w < 4; w++) begin
         send_b(ed[w][15:8], 1'b1);
         send_b(ed[w][7:0], 1'b1);
      end
      wait_done_b();
      chk("b_run_outputs", {b_if.halt, b_if.addr_oe, b_if.ram_en, b_if.address},
          {3'b000, 16'h0003});
      chk("b_nwrites", wr_b.size(), 4);
      for (int i = 0; i < 4 && i < wr_b.size(); i++)
         chk($sformatf("b_write%0d", i), {wr_b[i].addr, wr_b[i].data, 16'(wr_b[i].len)},
             {ea[i], ed[i], 16'd3});

      // LOAD_REQ from RUN re-halts and rewinds address
      b_if.load_req = 1'b1;
      @(posedge clk); #1;
      b_if.load_req = 1'b0;
      chk("b_reload", {b_if.halt, b_if.addr_oe, b_if.done, b_if.rx_ready, b_if.address},
          {4'b1101, 16'hFFFF});

      // Reset during the second cycle of a 3-cycle write
      send_b(8'h00, 1'b0);
      send_b(8'h01, 1'b0);
      send_b(8'hAA, 1'b0);
      send_b(8'h55, 1'b0);
      chk("b_write_cycle1", {b_if.ram_en, b_if.address, b_if.data_out}, {1'b1, 16'hFFFF, 16'hAA55});
      @(posedge clk); #1;
      chk("b_write_cycle2", {63'd0, b_if.ram_en}, 64'd1);
      rst_b = 1'b1;
      #1;
      chk("b_reset_midwrite",
          {b_if.rx_ready, b_if.halt, b_if.addr_oe, b_if.ram_en, b_if.ram_rw, b_if.data_oe,
           b_if.done, b_if.address, b_if.data_out},
          {7'b0110000, 16'hFFFF, 16'h0000});
      @(posedge clk); #1;
      rst_b = 1'b0;
      #1;
      chk("b_after_midwrite_reset", {b_if.rx_ready, b_if.halt, b_if.ram_en}, 3'b110);
      wr_b.delete();

      // Resent image completes normally
      send_b(8'h00, 1'b0);
      send_b(8'h01, 1'b0);
      send_b(8'h77, 1'b0);
      send_b(8'h88, 1'b0);
      wait_done_b();
      chk("b_resend_nwrites", wr_b.size(), 1);
      if (wr_b.size() > 0)
         chk("b_resend_write", {wr_b[0].addr, wr_b[0].data, 16'(wr_b[0].len)},
             {16'hFFFF, 16'h7788, 16'd3});
      chk("b_resend_run", {b_if.halt, b_if.done, b_if.address}, {2'b01, 16'h0000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
